// File: rtl/fft_addr_ctrl_pkg.sv
// rtl/fft_addr_ctrl_pkg.sv - shared constants, FSM encoding and butterfly address math
//
// Purpose: sizes for the 32-point radix-2 FFT sequencer, the controller state
// encoding, and the butterfly-index -> (G, H, twiddle) address mapping.
// Ports: none (package).
package fft_addr_ctrl_pkg;

  localparam int N_LOG2_DEF = 5;
  localparam int POINTS     = 1 << N_LOG2_DEF;
  localparam int HALF       = POINTS / 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [N_LOG2_DEF-1:0] g;
    logic [N_LOG2_DEF-1:0] h;
    logic [N_LOG2_DEF-2:0] tw;
  } bf_addr_t;

  // Butterfly b of stage s pairs G and G+span, where G inserts a zero at bit
  // position s of b. The twiddle index is the within-group offset scaled up so
  // that every stage indexes the same half-period ROM.
  function automatic bf_addr_t bf_addr(input logic [N_LOG2_DEF-2:0] b,
                                       input logic [2:0]            s);
    logic [N_LOG2_DEF-1:0] one;
    logic [N_LOG2_DEF-1:0] span;
    logic [N_LOG2_DEF-1:0] low;
    logic [N_LOG2_DEF-1:0] g;
    logic [N_LOG2_DEF-1:0] tw_full;
    bf_addr_t r;
    one     = N_LOG2_DEF'(1);
    span    = one << s;
    low     = {1'b0, b} & (span - one);
    g       = (({1'b0, b} >> s) << (s + 3'd1)) | low;
    tw_full = low << (3'(N_LOG2_DEF - 1) - s);
    r.g     = g;
    r.h     = g + span;
    r.tw    = tw_full[N_LOG2_DEF-2:0];
    return r;
  endfunction

endpackage

// File: rtl/clk_delay.sv
// rtl/clk_delay.sv - fixed-depth register pipeline
//
// Purpose: delays a bus by DEPTH clock cycles (DEPTH >= 1).
// Ports:
//   clk    in   1      rising-edge clock
//   clear  in   1      asynchronous active-high reset, pipeline flushes to 0
//   d      in   WIDTH  value entering the pipeline
//   q      out  WIDTH  value of d from DEPTH cycles earlier
module clk_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_addr_ctrl.sv
// rtl/fft_addr_ctrl.sv - sequencing controller for the in-place radix-2 FFT memory
//
// Purpose: runs LOAD (2^N_LOG2 samples) -> N_LOG2 compute stages -> DONE, driving
// MEM load/read/write addresses, ping-pong bank selects, butterfly valid and
// twiddle index. Every output is a flop.
// Ports:
//   clk, clear                  clock, asynchronous active-high reset
//   start, data_valid           frame start (IDLE only), sample present (LOAD only)
//   load_ready, load_data_write LOAD-phase handshake and MEM load-mode select
//   load_data_addr              index of the sample accepted this cycle
//   read_G_addr, read_H_addr    butterfly input addresses (valid with bf_valid)
//   write_G_addr, write_H_addr  butterfly result addresses (BF_LAT after read)
//   rw_addr_en                  0 read cycle, 1 write cycle
//   bank0/1_write_en            per-bank write strobes
//   bank_read_sel               bank read by the current stage
//   tw_addr, bf_valid           twiddle ROM index, butterfly input valid next cycle
//   stage, busy, done           stage index, non-IDLE flag, end-of-frame pulse
module fft_addr_ctrl
  import fft_addr_ctrl_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int BF_LAT = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              data_valid,
  output logic              load_ready,
  output logic              load_data_write,
  output logic [N_LOG2-1:0] load_data_addr,
  output logic [N_LOG2-1:0] read_G_addr,
  output logic [N_LOG2-1:0] read_H_addr,
  output logic [N_LOG2-1:0] write_G_addr,
  output logic [N_LOG2-1:0] write_H_addr,
  output logic              rw_addr_en,
  output logic              bank0_write_en,
  output logic              bank1_write_en,
  output logic              bank_read_sel,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_valid,
  output logic [2:0]        stage,
  output logic              busy,
  output logic              done
);

  localparam int AW   = N_LOG2;
  localparam int TW_W = N_LOG2 + 1;
  // Last local cycle of a stage is the final write: read of b=HALF-1 plus BF_LAT.
  localparam logic [TW_W-1:0] T_LAST    = TW_W'(2 * HALF - 2 + BF_LAT);
  localparam logic [TW_W-1:0] T_READS   = TW_W'(2 * HALF);
  localparam logic [2:0]      S_LAST    = 3'(N_LOG2 - 1);
  localparam logic [AW-1:0]   LOAD_LAST = AW'(POINTS - 1);

  state_t          state, state_nxt;
  logic [TW_W-1:0] t, t_nxt;
  logic [2:0]      stage_nxt;
  logic [AW-1:0]   load_nxt;
  logic            sel_nxt;

  logic            rd_valid_nxt;
  logic [AW-1:0]   rd_g_nxt, rd_h_nxt;
  logic [AW-2:0]   tw_nxt;
  bf_addr_t        bf;
  logic [2*AW:0]   dly_d, dly_q;

  // State register; stage, load_data_addr and bank_read_sel double as counters.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state          <= ST_IDLE;
      t              <= '0;
      stage          <= '0;
      load_data_addr <= '0;
      bank_read_sel  <= 1'b0;
    end else begin
      state          <= state_nxt;
      t              <= t_nxt;
      stage          <= stage_nxt;
      load_data_addr <= load_nxt;
      bank_read_sel  <= sel_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    stage_nxt = stage;
    load_nxt  = load_data_addr;
    sel_nxt   = bank_read_sel;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          sel_nxt   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (data_valid) begin
          load_nxt = load_data_addr + AW'(1);
          if (load_data_addr == LOAD_LAST) begin
            state_nxt = ST_COMPUTE;
            t_nxt     = '0;
            stage_nxt = '0;
          end
        end
      end
      ST_COMPUTE: begin
        if (t == T_LAST) begin
          t_nxt = '0;
          if (stage == S_LAST) begin
            state_nxt = ST_DONE;
            stage_nxt = '0;
            // Final results sit in the last stage's write bank.
            sel_nxt   = 1'(N_LOG2 % 2);
          end else begin
            stage_nxt = stage + 3'd1;
            sel_nxt   = ~stage[0];
          end
        end else begin
          t_nxt = t + TW_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from next-cycle state so the registered outputs line up with
  // the state register.
  always_comb begin
    bf           = bf_addr(t_nxt[AW-1:1], stage_nxt);
    rd_valid_nxt = (state_nxt == ST_COMPUTE) && !t_nxt[0] && (t_nxt < T_READS);
    rd_g_nxt     = '0;
    rd_h_nxt     = '0;
    tw_nxt       = '0;
    if (rd_valid_nxt) begin
      rd_g_nxt = bf.g;
      rd_h_nxt = bf.h;
      tw_nxt   = bf.tw;
    end
  end

  // Fed with next-cycle read values, so after DEPTH=BF_LAT plus the output
  // flop the write side trails the read side by exactly BF_LAT cycles.
  assign dly_d = {rd_g_nxt, rd_h_nxt, rd_valid_nxt};

  clk_delay #(
    .DEPTH (BF_LAT),
    .WIDTH (2 * AW + 1)
  ) u_wr_delay (
    .clk   (clk),
    .clear (clear),
    .d     (dly_d),
    .q     (dly_q)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      load_ready      <= 1'b0;
      load_data_write <= 1'b0;
      read_G_addr     <= '0;
      read_H_addr     <= '0;
      write_G_addr    <= '0;
      write_H_addr    <= '0;
      rw_addr_en      <= 1'b0;
      bank0_write_en  <= 1'b0;
      bank1_write_en  <= 1'b0;
      tw_addr         <= '0;
      bf_valid        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      load_ready      <= (state_nxt == ST_LOAD);
      load_data_write <= (state_nxt == ST_LOAD);
      read_G_addr     <= rd_g_nxt;
      read_H_addr     <= rd_h_nxt;
      tw_addr         <= tw_nxt;
      bf_valid        <= rd_valid_nxt;
      rw_addr_en      <= (state_nxt == ST_COMPUTE) && t_nxt[0];
      busy            <= (state_nxt != ST_IDLE);
      done            <= (state_nxt == ST_DONE);
      write_G_addr    <= dly_q[2*AW:AW+1];
      write_H_addr    <= dly_q[AW:1];
      // Stage s writes the bank it is not reading.
      bank0_write_en  <= dly_q[0] && (state_nxt == ST_COMPUTE) && stage_nxt[0];
      bank1_write_en  <= dly_q[0] && (state_nxt == ST_COMPUTE) && !stage_nxt[0];
    end
  end

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// tb/tb_fft_addr_ctrl.sv - self-checking bench for fft_addr_ctrl at BF_LAT 3 and 5
module tb_fft_addr_ctrl;

  logic clk = 1'b0;
  logic clear, start, data_valid;
  always #5 clk = ~clk;

  logic       lr[2], ldw[2], rw[2], b0[2], b1[2], sel[2], bv[2], busy[2], done[2];
  logic [4:0] lda[2], rg[2], rh[2], wg[2], wh[2];
  logic [3:0] tw[2];
  logic [2:0] stg[2];

  fft_addr_ctrl #(.N_LOG2(5), .BF_LAT(3)) dut3 (
    .clk(clk), .clear(clear), .start(start), .data_valid(data_valid),
    .load_ready(lr[0]), .load_data_write(ldw[0]), .load_data_addr(lda[0]),
    .read_G_addr(rg[0]), .read_H_addr(rh[0]), .write_G_addr(wg[0]), .write_H_addr(wh[0]),
    .rw_addr_en(rw[0]), .bank0_write_en(b0[0]), .bank1_write_en(b1[0]),
    .bank_read_sel(sel[0]), .tw_addr(tw[0]), .bf_valid(bv[0]), .stage(stg[0]),
    .busy(busy[0]), .done(done[0]));

  fft_addr_ctrl #(.N_LOG2(5), .BF_LAT(5)) dut5 (
    .clk(clk), .clear(clear), .start(start), .data_valid(data_valid),
    .load_ready(lr[1]), .load_data_write(ldw[1]), .load_data_addr(lda[1]),
    .read_G_addr(rg[1]), .read_H_addr(rh[1]), .write_G_addr(wg[1]), .write_H_addr(wh[1]),
    .rw_addr_en(rw[1]), .bank0_write_en(b0[1]), .bank1_write_en(b1[1]),
    .bank_read_sel(sel[1]), .tw_addr(tw[1]), .bf_valid(bv[1]), .stage(stg[1]),
    .busy(busy[1]), .done(done[1]));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input int i, input logic [31:0] act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s dut%0d @%0t actual=%0d required=%0d", name, i, $time, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 compute, 3 done; cnt = samples accepted or compute cycle.
  int lat[2]     = '{3, 5};
  int len_lit[2] = '{170, 180};
  int m_phase[2] = '{0, 0};
  int m_cnt[2]   = '{0, 0};
  int m_bank[2]  = '{0, 0};
  int cc[2]      = '{0, 0};

  task automatic model_step(input int i);
    int e_lr, e_lda, e_rg, e_rh, e_wg, e_wh, e_rw, e_b0, e_b1, e_sel, e_tw, e_bv, e_stg, e_busy, e_done;
    int len, s, t, b, span, wr;
    if (clear) begin
      m_phase[i] = 0; m_bank[i] = 0; m_cnt[i] = 0; cc[i] = 0;
    end
    e_lr = 0; e_lda = 0; e_rg = 0; e_rh = 0; e_wg = 0; e_wh = 0; e_rw = 0; e_b0 = 0; e_b1 = 0;
    e_sel = 0; e_tw = 0; e_bv = 0; e_stg = 0; e_busy = 0; e_done = 0; wr = 0;
    len = 31 + lat[i];
    case (m_phase[i])
      0: e_sel = m_bank[i];
      1: begin e_lr = 1; e_lda = m_cnt[i]; e_busy = 1; end
      2: begin
        s = m_cnt[i] / len; t = m_cnt[i] % len; span = 1 << s;
        e_busy = 1; e_stg = s; e_sel = s % 2; e_rw = t % 2;
        if (t % 2 == 0 && t < 32) begin
          b = t / 2; e_bv = 1;
          e_rg = (b / span) * 2 * span + b % span; e_rh = e_rg + span;
          e_tw = (b % span) * (16 / span);
        end
        if (t >= lat[i] && (t - lat[i]) % 2 == 0 && (t - lat[i]) / 2 < 16) begin
          wr = 1; b = (t - lat[i]) / 2;
          e_wg = (b / span) * 2 * span + b % span; e_wh = e_wg + span;
          if (s % 2 == 0) e_b1 = 1; else e_b0 = 1;
        end
      end
      default: begin e_done = 1; e_busy = 1; e_sel = 1; end
    endcase

    check("load_ready", i, 32'(lr[i]), e_lr);
    check("load_data_write", i, 32'(ldw[i]), e_lr);
    check("load_data_addr", i, 32'(lda[i]), e_lda);
    check("read_G_addr", i, 32'(rg[i]), e_rg);
    check("read_H_addr", i, 32'(rh[i]), e_rh);
    check("tw_addr", i, 32'(tw[i]), e_tw);
    check("bf_valid", i, 32'(bv[i]), e_bv);
    check("rw_addr_en", i, 32'(rw[i]), e_rw);
    check("bank0_write_en", i, 32'(b0[i]), e_b0);
    check("bank1_write_en", i, 32'(b1[i]), e_b1);
    check("bank_read_sel", i, 32'(sel[i]), e_sel);
    check("stage", i, 32'(stg[i]), e_stg);
    check("busy", i, 32'(busy[i]), e_busy);
    check("done", i, 32'(done[i]), e_done);
    if (wr != 0) begin
      check("write_G_addr", i, 32'(wg[i]), e_wg);
      check("write_H_addr", i, 32'(wh[i]), e_wh);
    end
    check("bank_overlap", i, 32'(b0[i] & b1[i]), 0);
    check("write_on_read", i, 32'((b0[i] | b1[i]) & ~rw[i]), 0);

    // Hand-computed anchors.
    if (m_phase[i] == 2) begin
      if (m_cnt[i] == lat[i]) begin
        check("lit_first_wr_bank1", i, 32'(b1[i]), 1);
        check("lit_first_wr_rw", i, 32'(rw[i]), 1);
        check("lit_first_wr_G", i, 32'(wg[i]), 0);
        check("lit_first_wr_H", i, 32'(wh[i]), 1);
      end
      if (i == 0) begin
        if (m_cnt[i] == 0)   begin check("lit_s0b0_G", i, 32'(rg[i]), 0);  check("lit_s0b0_H", i, 32'(rh[i]), 1); end
        if (m_cnt[i] == 2)   begin check("lit_s0b1_G", i, 32'(rg[i]), 2);  check("lit_s0b1_H", i, 32'(rh[i]), 3); end
        if (m_cnt[i] == 30)  begin check("lit_s0b15_G", i, 32'(rg[i]), 30); check("lit_s0b15_H", i, 32'(rh[i]), 31);
                                   check("lit_s0b15_tw", i, 32'(tw[i]), 0); end
        if (m_cnt[i] == 136) begin check("lit_s4b0_G", i, 32'(rg[i]), 0);  check("lit_s4b0_H", i, 32'(rh[i]), 16);
                                   check("lit_s4_sel", i, 32'(sel[i]), 0); end
        if (m_cnt[i] == 139) check("lit_s4_wbank1", i, 32'(b1[i]), 1);
        if (m_cnt[i] == 146) begin check("lit_s4b5_G", i, 32'(rg[i]), 5);  check("lit_s4b5_H", i, 32'(rh[i]), 21);
                                   check("lit_s4b5_tw", i, 32'(tw[i]), 5); end
      end
    end

    // Compute-phase length measured from DUT outputs alone.
    if (busy[i] && !lr[i] && !done[i]) cc[i]++;
    if (done[i]) begin
      check("lit_compute_len", i, 32'(cc[i]), len_lit[i]);
      cc[i] = 0;
    end

    if (!clear) begin
      case (m_phase[i])
        0: if (start) begin m_phase[i] = 1; m_cnt[i] = 0; m_bank[i] = 0; end
        1: if (data_valid) begin
             m_cnt[i]++;
             if (m_cnt[i] == 32) begin m_phase[i] = 2; m_cnt[i] = 0; end
           end
        2: begin
             m_cnt[i]++;
             if (m_cnt[i] == 5 * len) m_phase[i] = 3;
           end
        default: begin m_phase[i] = 0; m_bank[i] = 1; end
      endcase
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      step();
      n++;
    end
    tests_run++;
    if (busy[0] || busy[1]) begin
      tests_failed++;
      $display("FAIL wait_idle timeout after %0d cycles", budget);
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;

    // Samples offered while idle must be ignored.
    data_valid = 1'b1;
    repeat (3) step();
    data_valid = 1'b0;
    step();

    // Frame 1: load with gaps of 0..2 cycles.
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      data_valid = 1'b0;
      repeat (k % 3) step();
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    repeat (20) step();
    start = 1'b1; data_valid = 1'b1; step();
    start = 1'b0; data_valid = 1'b0;
    wait_idle(400);
    repeat (2) step();

    // Frame 2: aborted by clear mid-compute.
    start = 1'b1; step(); start = 1'b0;
    data_valid = 1'b1; repeat (32) step(); data_valid = 1'b0;
    repeat (60) step();
    clear = 1'b1; step(); clear = 1'b0;
    step();

    // Frame 3: full run after the abort.
    start = 1'b1; step(); start = 1'b0;
    data_valid = 1'b1; repeat (32) step(); data_valid = 1'b0;
    wait_idle(400);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
